// File: rtl/traffic_pkg.sv
// Shared state encodings, default phase durations and the per-state lamp decode
// for the two-road intersection controller.
package traffic_pkg;

    typedef enum logic [2:0] {
        ST_MAIN_GREEN  = 3'd0,
        ST_MAIN_YELLOW = 3'd1,
        ST_ALL_RED_A   = 3'd2,
        ST_WALK        = 3'd3,
        ST_SIDE_GREEN  = 3'd4,
        ST_SIDE_YELLOW = 3'd5,
        ST_ALL_RED_B   = 3'd6
    } state_e;

    localparam int DEF_MAIN_MIN_CYCLES   = 20;
    localparam int DEF_SIDE_GREEN_CYCLES = 16;
    localparam int DEF_YELLOW_CYCLES     = 7;
    localparam int DEF_ALL_RED_CYCLES    = 2;
    localparam int DEF_WALK_CYCLES       = 10;
    localparam int DEF_CNT_W             = 8;

    typedef struct packed {
        logic main_red;
        logic main_yellow;
        logic main_green;
        logic side_red;
        logic side_yellow;
        logic side_green;
        logic walk;
    } lamps_t;

    // Unused encodings show all-red so a corrupted state never lights a green.
    function automatic lamps_t lamps_for(input logic [2:0] st);
        lamps_t l;
        l = '{main_red: 1'b1, side_red: 1'b1, default: 1'b0};
        case (st)
            ST_MAIN_GREEN: begin
                l.main_red   = 1'b0;
                l.main_green = 1'b1;
            end
            ST_MAIN_YELLOW: begin
                l.main_red    = 1'b0;
                l.main_yellow = 1'b1;
            end
            ST_WALK:        l.walk = 1'b1;
            ST_SIDE_GREEN: begin
                l.side_red   = 1'b0;
                l.side_green = 1'b1;
            end
            ST_SIDE_YELLOW: begin
                l.side_red    = 1'b0;
                l.side_yellow = 1'b1;
            end
            default: ;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/dwell_counter.sv
// Dwell timer: counts enabled cycles, clears on state change, saturates at i_limit.
// o_tc flags the terminal count combinationally from the registered value.
module dwell_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic [CNT_W-1:0] i_limit,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_tc
);

    logic [CNT_W-1:0] r_cnt;
    logic             w_tc;

    assign w_tc = (r_cnt == i_limit);

    // Clear is not gated by enable so an illegal-state recovery still zeroes the count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !w_tc) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;
    assign o_tc  = w_tc;

endmodule

// File: rtl/traffic_intersection_fsm.sv
// Main/side/pedestrian intersection sequencer with latched requests and all-red clearance.
// Lamps are a Moore decode of the state register; enable=0 freezes state and timer.
module traffic_intersection_fsm
    import traffic_pkg::*;
#(
    parameter int MAIN_MIN_CYCLES   = DEF_MAIN_MIN_CYCLES,
    parameter int SIDE_GREEN_CYCLES = DEF_SIDE_GREEN_CYCLES,
    parameter int YELLOW_CYCLES     = DEF_YELLOW_CYCLES,
    parameter int ALL_RED_CYCLES    = DEF_ALL_RED_CYCLES,
    parameter int WALK_CYCLES       = DEF_WALK_CYCLES,
    parameter int CNT_W             = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       side_req,
    input  logic       ped_btn,
    output logic       main_red,
    output logic       main_yellow,
    output logic       main_green,
    output logic       side_red,
    output logic       side_yellow,
    output logic       side_green,
    output logic       walk,
    output logic [2:0] phase
);

    localparam logic [CNT_W-1:0] LIM_MAIN   = CNT_W'(MAIN_MIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] LIM_SIDE   = CNT_W'(SIDE_GREEN_CYCLES - 1);
    localparam logic [CNT_W-1:0] LIM_YELLOW = CNT_W'(YELLOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] LIM_ALLRED = CNT_W'(ALL_RED_CYCLES - 1);
    localparam logic [CNT_W-1:0] LIM_WALK   = CNT_W'(WALK_CYCLES - 1);

    logic [2:0]       r_state;
    logic [2:0]       w_next;
    logic             r_side_pend;
    logic             r_ped_pend;
    logic [CNT_W-1:0] w_limit;
    logic [CNT_W-1:0] w_cnt;
    logic             w_tc;
    logic             w_adv;
    logic             w_chg;
    lamps_t           w_lamps;

    always_comb begin
        w_limit = '0;
        case (r_state)
            ST_MAIN_GREEN:  w_limit = LIM_MAIN;
            ST_MAIN_YELLOW: w_limit = LIM_YELLOW;
            ST_ALL_RED_A:   w_limit = LIM_ALLRED;
            ST_WALK:        w_limit = LIM_WALK;
            ST_SIDE_GREEN:  w_limit = LIM_SIDE;
            ST_SIDE_YELLOW: w_limit = LIM_YELLOW;
            ST_ALL_RED_B:   w_limit = LIM_ALLRED;
            default:        w_limit = '0;
        endcase
    end

    dwell_counter #(
        .CNT_W (CNT_W)
    ) u_dwell (
        .clk     (clk),
        .reset_n (reset_n),
        .i_en    (enable),
        .i_clr   (w_chg),
        .i_limit (w_limit),
        .o_cnt   (w_cnt),
        .o_tc    (w_tc)
    );

    // Main green's counter saturates at its limit, so w_tc there means cnt >= MAIN_MIN-1.
    assign w_adv = enable && w_tc;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_MAIN_GREEN:  if (w_adv && (r_side_pend || r_ped_pend)) w_next = ST_MAIN_YELLOW;
            ST_MAIN_YELLOW: if (w_adv) w_next = ST_ALL_RED_A;
            ST_ALL_RED_A:   if (w_adv) w_next = r_ped_pend ? ST_WALK : ST_SIDE_GREEN;
            ST_WALK:        if (w_adv) w_next = r_side_pend ? ST_SIDE_GREEN : ST_MAIN_GREEN;
            ST_SIDE_GREEN:  if (w_adv) w_next = ST_SIDE_YELLOW;
            ST_SIDE_YELLOW: if (w_adv) w_next = ST_ALL_RED_B;
            ST_ALL_RED_B:   if (w_adv) w_next = ST_MAIN_GREEN;
            default:        w_next = ST_ALL_RED_B;
        endcase
    end

    assign w_chg = (w_next != r_state);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_ALL_RED_B;
        end else begin
            r_state <= w_next;
        end
    end

    // Entering the serving phase absorbs any request that arrives on the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_side_pend <= 1'b0;
            r_ped_pend  <= 1'b0;
        end else begin
            if (w_next == ST_SIDE_GREEN && r_state != ST_SIDE_GREEN) begin
                r_side_pend <= 1'b0;
            end else begin
                r_side_pend <= r_side_pend | side_req;
            end
            if (w_next == ST_WALK && r_state != ST_WALK) begin
                r_ped_pend <= 1'b0;
            end else begin
                r_ped_pend <= r_ped_pend | ped_btn;
            end
        end
    end

    assign w_lamps     = lamps_for(r_state);
    assign main_red    = w_lamps.main_red;
    assign main_yellow = w_lamps.main_yellow;
    assign main_green  = w_lamps.main_green;
    assign side_red    = w_lamps.side_red;
    assign side_yellow = w_lamps.side_yellow;
    assign side_green  = w_lamps.side_green;
    assign walk        = w_lamps.walk;
    assign phase       = r_state;

endmodule
